// File: rtl/tread_input_mapper.sv
// rtl/tread_input_mapper.sv - joystick/PS2 merge, debounce and tread direction mapping per player
// Optional debounce stage is compiled in with TREAD_DEBOUNCE_EN.

module tread_input_mapper #(
    parameter int PLAYERS    = 2,
    parameter int DEB_CYCLES = 16,
    parameter int COIN_PULSE = 1024
) (
    input  logic                   clk_sys,
    input  logic                   Reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [16*PLAYERS-1:0]  joy_i,
    output logic [2*PLAYERS-1:0]   fw_n,
    output logic [2*PLAYERS-1:0]   bk_n,
    output logic [PLAYERS-1:0]     fire,
    output logic [1:0]             start_n,
    output logic                   coin_n
);

    localparam int CW = $clog2(COIN_PULSE + 1);

    // key_q bit order: P0 R,L,D,U,fire; P1 R,L,D,U,fire; start1 x2; start2 x2; coin x3
    localparam int NKEYS = 17;

    function automatic logic [NKEYS-1:0] key_hit(input logic [8:0] code);
        logic [NKEYS-1:0] h;
        h     = '0;
        h[0]  = (code[7:0] == 8'h74);
        h[1]  = (code[7:0] == 8'h6B);
        h[2]  = (code[7:0] == 8'h72);
        h[3]  = (code[7:0] == 8'h75);
        h[4]  = (code == 9'h014);
        h[5]  = (code == 9'h034);
        h[6]  = (code == 9'h023);
        h[7]  = (code == 9'h02B);
        h[8]  = (code == 9'h02D);
        h[9]  = (code == 9'h01C);
        h[10] = (code == 9'h016);
        h[11] = (code == 9'h005);
        h[12] = (code == 9'h01E);
        h[13] = (code == 9'h006);
        h[14] = (code == 9'h02E);
        h[15] = (code == 9'h036);
        h[16] = (code == 9'h004);
        return h;
    endfunction

    // {U,D,L,R} -> {A fw, A bk, B fw, B bk}; anything ambiguous idles both treads
    function automatic logic [3:0] tread_decode(input logic [3:0] d);
        case (d)
            4'b1000: return 4'b1010;
            4'b1001: return 4'b1000;
            4'b0001: return 4'b1001;
            4'b0101: return 4'b0100;
            4'b0100: return 4'b0101;
            4'b0110: return 4'b0001;
            4'b0010: return 4'b0110;
            4'b1010: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    logic             tgl_q;
    logic [NKEYS-1:0] key_q;
    logic             key_ev;
    logic [NKEYS-1:0] hit;

    assign key_ev = (ps2_key[10] != tgl_q);
    assign hit    = key_hit(ps2_key[8:0]);

    always_ff @(posedge clk_sys) begin
        tgl_q <= ps2_key[10];
        if (!Reset_n)
            key_q <= '0;
        else if (key_ev)
            key_q <= (key_q & ~hit) | (hit & {NKEYS{ps2_key[9]}});
    end

    logic [3:0]         raw_dir [PLAYERS];
    logic [PLAYERS-1:0] raw_fire;
    logic               raw_s1, raw_s2, raw_coin;
    logic               unused_joy;

    always_comb begin
        raw_s1     = key_q[10] | key_q[11];
        raw_s2     = key_q[12] | key_q[13];
        raw_coin   = key_q[14] | key_q[15] | key_q[16];
        unused_joy = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            raw_dir[p]  = joy_i[16*p +: 4];
            raw_fire[p] = joy_i[16*p+4];
            raw_s1      = raw_s1   | joy_i[16*p+5];
            raw_s2      = raw_s2   | joy_i[16*p+6];
            raw_coin    = raw_coin | joy_i[16*p+7];
            unused_joy  = unused_joy ^ (^joy_i[16*p+8 +: 8]);
            if (p == 0) begin
                raw_dir[p]  = raw_dir[p] | key_q[3:0];
                raw_fire[p] = raw_fire[p] | key_q[4];
            end
            if (p == 1) begin
                raw_dir[p]  = raw_dir[p] | key_q[8:5];
                raw_fire[p] = raw_fire[p] | key_q[9];
            end
        end
    end

    logic [3:0]         s_q   [PLAYERS];
    logic [3:0]         acc_q [PLAYERS];
    logic [PLAYERS-1:0] fire_q;
    logic               s1_q, s2_q, coin_q, coin_d;

    always_ff @(posedge clk_sys) begin
        if (!Reset_n) begin
            for (int p = 0; p < PLAYERS; p++) s_q[p] <= '0;
            fire_q <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            coin_q <= 1'b0;
            coin_d <= 1'b0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) s_q[p] <= raw_dir[p];
            fire_q <= raw_fire;
            s1_q   <= raw_s1;
            s2_q   <= raw_s2;
            coin_q <= raw_coin;
            coin_d <= coin_q;
        end
    end

`ifdef TREAD_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [3:0] c_q [PLAYERS];
    logic [7:0] n_q [PLAYERS];

    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < PLAYERS; p++) begin
            if (!Reset_n) begin
                c_q[p]   <= '0;
                n_q[p]   <= '0;
                acc_q[p] <= '0;
            end else if (s_q[p] != c_q[p]) begin
                c_q[p] <= s_q[p];
                n_q[p] <= '0;
            end else if (n_q[p] == DEB_LAST) begin
                acc_q[p] <= c_q[p];
            end else begin
                n_q[p] <= n_q[p] + 8'd1;
            end
        end
    end
`else
    logic unused_deb;
    assign unused_deb = (DEB_CYCLES > 0);

    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < PLAYERS; p++) begin
            if (!Reset_n)
                acc_q[p] <= '0;
            else
                acc_q[p] <= s_q[p];
        end
    end
`endif

    logic [3:0] tr [PLAYERS];

    always_comb begin
        for (int p = 0; p < PLAYERS; p++) tr[p] = tread_decode(acc_q[p]);
    end

    logic [CW-1:0] coin_cnt;

    always_ff @(posedge clk_sys) begin
        if (!Reset_n) begin
            fw_n     <= '1;
            bk_n     <= '1;
            fire     <= '0;
            start_n  <= 2'b11;
            coin_n   <= 1'b1;
            coin_cnt <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                fw_n[2*p]   <= ~tr[p][3];
                bk_n[2*p]   <= ~tr[p][2];
                fw_n[2*p+1] <= ~tr[p][1];
                bk_n[2*p+1] <= ~tr[p][0];
            end
            fire    <= fire_q;
            start_n <= {~s2_q, ~s1_q};
            // Rising edges are only looked at while the counter is idle
            if (coin_cnt != '0) begin
                coin_cnt <= coin_cnt - CW'(1);
                coin_n   <= (coin_cnt == CW'(1));
            end else if (coin_q && !coin_d) begin
                coin_cnt <= CW'(COIN_PULSE);
                coin_n   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tread_input_mapper.sv
// tb/tb_tread_input_mapper.sv - vector table plus scoreboard bench for tread_input_mapper

module tb_tread_input_mapper;

    localparam int PLAYERS = 2;
    localparam int DEB     = 16;
    localparam int CP      = 8;
`ifdef TREAD_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic        clk_sys = 1'b0;
    logic        Reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joy_i;
    logic [3:0]  fw_n, bk_n;
    logic [1:0]  fire;
    logic [1:0]  start_n;
    logic        coin_n;

    always #5 clk_sys = ~clk_sys;

    tread_input_mapper #(.PLAYERS(PLAYERS), .DEB_CYCLES(DEB), .COIN_PULSE(CP)) dut (
        .clk_sys (clk_sys),
        .Reset_n (Reset_n),
        .ps2_key (ps2_key),
        .joy_i   (joy_i),
        .fw_n    (fw_n),
        .bk_n    (bk_n),
        .fire    (fire),
        .start_n (start_n),
        .coin_n  (coin_n)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_ev(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    // drv[k] is the coin level applied before edge k+1; low[k] means coin_n is 0 after edge k+1
    task automatic coin_seq(input string name, input logic [63:0] drv, input logic [63:0] low, input int len);
        for (int k = 0; k < len; k++) begin
            joy_i[7] = drv[k];
            tick();
            check($sformatf("%s_e%0d", name, k + 1), {15'd0, coin_n}, {15'd0, ~low[k]});
        end
    endtask

    typedef struct {
        logic [3:0] j0;
        logic [3:0] j1;
        logic [3:0] fw;
        logic [3:0] bk;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] fw;
        logic [3:0] bk;
    } exp_t;

    vec_t vt[14];
    exp_t sb[$];

    initial begin
        exp_t       e;
        logic [3:0] prev_fw, prev_bk;
        int         changed;

        vt[0]  = '{4'b1000, 4'b0000, 4'b1100, 4'b1111, "p0_up"};
        vt[1]  = '{4'b1001, 4'b0000, 4'b1110, 4'b1111, "p0_up_right"};
        vt[2]  = '{4'b0001, 4'b0000, 4'b1110, 4'b1101, "p0_right"};
        vt[3]  = '{4'b0101, 4'b0000, 4'b1111, 4'b1110, "p0_down_right"};
        vt[4]  = '{4'b0100, 4'b0000, 4'b1111, 4'b1100, "p0_down"};
        vt[5]  = '{4'b0110, 4'b0000, 4'b1111, 4'b1101, "p0_down_left"};
        vt[6]  = '{4'b0010, 4'b0000, 4'b1101, 4'b1110, "p0_left"};
        vt[7]  = '{4'b1010, 4'b0000, 4'b1101, 4'b1111, "p0_up_left"};
        vt[8]  = '{4'b1100, 4'b0000, 4'b1111, 4'b1111, "p0_up_down"};
        vt[9]  = '{4'b0011, 4'b0000, 4'b1111, 4'b1111, "p0_left_right"};
        vt[10] = '{4'b1110, 4'b0000, 4'b1111, 4'b1111, "p0_three_bits"};
        vt[11] = '{4'b0000, 4'b0001, 4'b1011, 4'b0111, "p1_right"};
        vt[12] = '{4'b0100, 4'b1000, 4'b0011, 4'b1100, "p0_down_p1_up"};
        vt[13] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, "all_idle"};

        // Reset with the PS/2 toggle high: no event may follow release
        Reset_n = 1'b0;
        ps2_key = 11'h400;
        joy_i   = '0;
        tick();
        tick();
        check("reset_dir", {fw_n, bk_n}, 16'h00FF);
        check("reset_misc", {fire, start_n, coin_n}, {2'b00, 2'b11, 1'b1});
        Reset_n = 1'b1;
        changed = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if ({fw_n, bk_n, fire, start_n, coin_n} !== {8'hFF, 2'b00, 2'b11, 1'b1}) changed++;
        end
        check("post_reset_idle", 16'(changed), 16'd0);

        // Direction table through the scoreboard, including the exact latency edge
        prev_fw = 4'hF;
        prev_bk = 4'hF;
        for (int i = 0; i < 14; i++) begin
            joy_i = {12'd0, vt[i].j1, 12'd0, vt[i].j0};
            sb.push_back('{vt[i].fw, vt[i].bk});
            for (int k = 1; k < LAT; k++) tick();
            check({vt[i].name, "_early"}, {8'd0, fw_n, bk_n}, {8'd0, prev_fw, prev_bk});
            tick();
            e = sb.pop_front();
            check(vt[i].name, {8'd0, fw_n, bk_n}, {8'd0, e.fw, e.bk});
            prev_fw = e.fw;
            prev_bk = e.bk;
        end

        // Short P1 right glitch of 10 cycles
        joy_i = 32'h0001_0000;
        for (int k = 0; k < 10; k++) tick();
`ifdef TREAD_DEBOUNCE_EN
        check("glitch_mid", {8'd0, fw_n, bk_n}, 16'h00FF);
`else
        check("glitch_mid", {8'd0, fw_n, bk_n}, 16'h00B7);
`endif
        joy_i = '0;
        changed = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
`ifdef TREAD_DEBOUNCE_EN
            if ({fw_n, bk_n} !== 8'hFF) changed++;
`endif
        end
        check("glitch_after", {8'd0, fw_n, bk_n}, 16'h00FF);
        check("glitch_never_seen", 16'(changed), 16'd0);

        // Same input held long enough is accepted
        joy_i = 32'h0001_0000;
        for (int k = 0; k < LAT; k++) tick();
        check("p1_right_held", {8'd0, fw_n, bk_n}, 16'h00B7);
        joy_i = '0;
        for (int k = 0; k < LAT; k++) tick();
        check("p1_right_release", {8'd0, fw_n, bk_n}, 16'h00FF);

        // Keyboard P0 up via the extended code, one edge slower than the joystick
        ps2_ev(1'b1, 9'h175);
        for (int k = 0; k < LAT; k++) tick();
        check("kbd_up_early", {8'd0, fw_n, bk_n}, 16'h00FF);
        tick();
        check("kbd_up", {8'd0, fw_n, bk_n}, 16'h00CF);
        joy_i = 32'h0000_0008;
        tick();
        tick();
        ps2_ev(1'b0, 9'h175);
        changed = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if ({fw_n, bk_n} !== 8'hCF) changed++;
        end
        check("kbd_joy_or_hold", 16'(changed), 16'd0);
        joy_i = '0;
        for (int k = 0; k < LAT; k++) tick();
        check("kbd_joy_released", {8'd0, fw_n, bk_n}, 16'h00FF);

        // Unmapped code changes nothing
        ps2_ev(1'b1, 9'h015);
        for (int k = 0; k < LAT + 2; k++) tick();
        check("unmapped_key", {8'd0, fw_n, bk_n, fire, start_n}, 16'h0FF3 << 0);

        // PS/2 start1 press and release
        ps2_ev(1'b1, 9'h016);
        tick();
        tick();
        check("start1_early", {14'd0, start_n}, 16'd3);
        tick();
        check("start1_kbd", {14'd0, start_n}, 16'd2);
        ps2_ev(1'b0, 9'h016);
        for (int k = 0; k < 3; k++) tick();
        check("start1_release", {14'd0, start_n}, 16'd3);

        // Joystick start2 on P1 and fire on P0: two edges
        joy_i = 32'h0040_0010;
        tick();
        check("fire_start2_early", {12'd0, fire, start_n}, 16'h3);
        tick();
        check("fire_start2", {12'd0, fire, start_n}, 16'h5);
        joy_i = '0;
        tick();
        tick();

        // PS/2 P1 fire
        ps2_ev(1'b1, 9'h01C);
        tick();
        tick();
        tick();
        check("p1_fire_kbd", {14'd0, fire}, 16'd2);
        ps2_ev(1'b0, 9'h01C);
        tick();
        tick();
        tick();
        check("p1_fire_kbd_release", {14'd0, fire}, 16'd0);

        // Coin held: one pulse of CP cycles after two edges
        coin_seq("coin_held", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1FE, 64);
        changed = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (coin_n !== 1'b1) changed++;
        end
        check("coin_held_single", 16'(changed), 16'd0);
        coin_seq("coin_release", 64'h0, 64'h0, 12);

        // Edges mid-pulse and in the final pulse cycle are dropped
        coin_seq("coin_reedge", 64'h000F_FF27, 64'h1FE, 30);
        coin_seq("coin_gap", 64'h0, 64'h0, 6);
        coin_seq("coin_again", 64'h3FFF, 64'h1FE, 14);
        coin_seq("coin_gap2", 64'h0, 64'h0, 6);

        // PS/2 coin: three edges
        ps2_ev(1'b1, 9'h02E);
        tick();
        tick();
        check("coin_kbd_early", {15'd0, coin_n}, 16'd1);
        tick();
        check("coin_kbd_start", {15'd0, coin_n}, 16'd0);
        for (int k = 0; k < CP - 1; k++) tick();
        check("coin_kbd_last", {15'd0, coin_n}, 16'd0);
        tick();
        check("coin_kbd_end", {15'd0, coin_n}, 16'd1);
        ps2_ev(1'b0, 9'h02E);
        for (int k = 0; k < 4; k++) tick();

        // Reset mid-pulse ends it on that edge
        joy_i[7] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("coin_pre_reset", {15'd0, coin_n}, 16'd0);
        joy_i[7] = 1'b0;
        Reset_n  = 1'b0;
        tick();
        check("coin_reset_mid", {15'd0, coin_n}, 16'd1);
        Reset_n = 1'b1;
        changed = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (coin_n !== 1'b1) changed++;
        end
        check("coin_after_reset", 16'(changed), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
